// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store front end for the data memory.
// Partial-byte stores are done as read-modify-write over the memory read latency.
module mem_access_ctrl #(
    parameter int N       = 256,
    parameter int M       = 32,
    parameter int LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [$clog2(N)-1:0]   req_addr,
    input  logic [M-1:0]           req_wdata,
    input  logic [M/8-1:0]         req_be,
    output logic                   rsp_valid,
    output logic [M-1:0]           rsp_rdata,
    output logic                   mem_we,
    output logic [$clog2(N)-1:0]   mem_waddr,
    output logic [M-1:0]           mem_wdata,
    output logic                   mem_re,
    output logic [$clog2(N)-1:0]   mem_raddr,
    input  logic [M-1:0]           mem_rdata
);

    localparam int AW = $clog2(N);
    localparam int BE = M / 8;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        RMW_RD = 2'd2,
        WRITE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [M-1:0]    wdata_q, wdata_d;
    logic [BE-1:0]   be_q, be_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [M-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [M-1:0]    merged;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Lanes with an enable take the store data, the rest keep the old word.
    always_comb begin
        merged = '0;
        for (int i = 0; i < BE; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8]
                                       : mem_rdata[8*i +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = CW'(LATENCY - 1);
                    if (!req_we) begin
                        state_d = READ;
                    end else if (req_be == '1 || req_be == '0) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            READ: begin
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RMW_RD: begin
                if (cnt_q == '0) begin
                    state_d = WRITE;
                    wdata_d = merged;
                    be_d    = '1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WRITE: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // A zero byte-enable store passes through WRITE without touching memory.
    always_comb begin
        req_ready = (state_q == IDLE) && rstn;
        mem_re    = rstn && (state_q == READ || state_q == RMW_RD);
        mem_we    = rstn && (state_q == WRITE) && (be_q != '0);
        mem_raddr = addr_q;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
        rsp_valid = rsp_valid_q;
        rsp_rdata = rsp_rdata_q;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural memory model.
// Expected values are hand-computed per vector.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic [7:0]  mem_raddr;
    logic [31:0] mem_rdata;

    logic [31:0] mem [256];
    int          we_cnt;
    int          re_cnt;
    int          both_cnt;
    int          vecs;
    int          errs;

    mem_access_ctrl #(.N(256), .M(32), .LATENCY(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_re ? mem[mem_raddr] : 32'h0;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] = mem_wdata;
            we_cnt = we_cnt + 1;
        end
        if (mem_re) re_cnt = re_cnt + 1;
        if (mem_we && mem_re) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs = vecs + 1;
        if (got !== exp) begin
            errs = errs + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait (bounded) for its response.
    task automatic xact(input logic we, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rd, output int lat);
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        cyc();
        req_valid = 1'b0;
        lat = 0;
        rd  = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            if (rsp_valid) begin
                lat = k - 1;
                break;
            end
            cyc();
            if (k == 20) chk("rsp_timeout", 32'd0, 32'd1);
        end
        if (lat == 0) lat = 0;
        rd = rsp_rdata;
    endtask

    logic [31:0] rd;
    int          lat;
    int          w0;
    int          r0;

    initial begin
        vecs = 0;
        errs = 0;
        we_cnt = 0;
        re_cnt = 0;
        both_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rstn      = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h10;
        req_wdata = 32'h5555_5555;
        req_be    = 4'hF;

        // 1. reset with a request pending
        repeat (3) cyc();
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_re", {31'd0, mem_re}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_waddr", {24'd0, mem_waddr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        req_valid = 1'b0;
        rstn = 1'b1;
        cyc();
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("post_rst_no_write", we_cnt, 32'd0);

        // 2. full store then load
        w0 = we_cnt;
        xact(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, rd, lat);
        chk("st_full_lat", lat, 32'd1);
        chk("st_full_rdata", rd, 32'd0);
        chk("st_full_wecnt", we_cnt - w0, 32'd1);
        chk("st_full_mem", mem[8'h10], 32'hDEAD_BEEF);
        cyc();
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        xact(1'b0, 8'h10, 32'h0, 4'h0, rd, lat);
        chk("ld_lat", lat, 32'd2);
        chk("ld_rdata", rd, 32'hDEAD_BEEF);
        cyc();

        // 3. partial store (read-modify-write)
        w0 = we_cnt;
        r0 = re_cnt;
        xact(1'b1, 8'h10, 32'h0000_AA00, 4'b0010, rd, lat);
        chk("rmw_lat", lat, 32'd3);
        chk("rmw_rdata", rd, 32'd0);
        chk("rmw_recnt", re_cnt - r0, 32'd2);
        chk("rmw_wecnt", we_cnt - w0, 32'd1);
        chk("rmw_mem", mem[8'h10], 32'hDEAD_AAEF);
        cyc();
        xact(1'b0, 8'h10, 32'h0, 4'h0, rd, lat);
        chk("rmw_ld", rd, 32'hDEAD_AAEF);
        cyc();

        // 4. back-to-back loads with req_valid held
        mem[8'hFF] = 32'hA5A5_0001;
        mem[8'h00] = 32'h0BAD_F00D;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'hFF;
        cyc();
        req_addr = 8'h00;
        chk("b2b_busy1", {31'd0, req_ready}, 32'd0);
        cyc();
        chk("b2b_busy2", {31'd0, req_ready}, 32'd0);
        chk("b2b_no_rsp_e1", {31'd0, rsp_valid}, 32'd0);
        cyc();
        chk("b2b_rsp1_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b_rsp1_data", rsp_rdata, 32'hA5A5_0001);
        chk("b2b_ready_e2", {31'd0, req_ready}, 32'd1);
        cyc();
        req_valid = 1'b0;
        chk("b2b_busy3", {31'd0, req_ready}, 32'd0);
        chk("b2b_rsp_gap", {31'd0, rsp_valid}, 32'd0);
        cyc();
        chk("b2b_no_rsp_e4", {31'd0, rsp_valid}, 32'd0);
        cyc();
        chk("b2b_rsp2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b_rsp2_data", rsp_rdata, 32'h0BAD_F00D);
        cyc();

        // 5. reset during the read phase of a partial store
        mem[8'h20] = 32'h1234_5678;
        w0 = we_cnt;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h20;
        req_wdata = 32'hFFFF_FFFF;
        req_be    = 4'b0001;
        cyc();
        req_valid = 1'b0;
        chk("abort_in_rmw", {31'd0, mem_re}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("abort_re_low", {31'd0, mem_re}, 32'd0);
        repeat (2) cyc();
        rstn = 1'b1;
        repeat (3) cyc();
        chk("abort_no_write", we_cnt - w0, 32'd0);
        chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        xact(1'b0, 8'h20, 32'h0, 4'h0, rd, lat);
        chk("abort_ld", rd, 32'h1234_5678);
        cyc();

        // 6. store with no byte enables
        mem[8'h30] = 32'hCAFE_BABE;
        w0 = we_cnt;
        r0 = re_cnt;
        xact(1'b1, 8'h30, 32'h1111_1111, 4'h0, rd, lat);
        chk("be0_lat", lat, 32'd1);
        chk("be0_wecnt", we_cnt - w0, 32'd0);
        chk("be0_recnt", re_cnt - r0, 32'd0);
        cyc();
        xact(1'b0, 8'h30, 32'h0, 4'h0, rd, lat);
        chk("be0_ld", rd, 32'hCAFE_BABE);
        cyc();

        chk("we_re_exclusive", both_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
